// File: rtl/bus_cycle_pkg.sv
// Shared definitions for the 8088-style bus cycle initiator and its neighbours:
// bus-cycle states, S2..S0 status codes and request classification helpers.
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TW   = 3'd4,
    T4   = 3'd5
  } bus_state_e;

  localparam logic [2:0] STATUS_INTA      = 3'b000;
  localparam logic [2:0] STATUS_IO_READ   = 3'b001;
  localparam logic [2:0] STATUS_IO_WRITE  = 3'b010;
  localparam logic [2:0] STATUS_HALT      = 3'b011;
  localparam logic [2:0] STATUS_CODE      = 3'b100;
  localparam logic [2:0] STATUS_MEM_READ  = 3'b101;
  localparam logic [2:0] STATUS_MEM_WRITE = 3'b110;
  localparam logic [2:0] STATUS_PASSIVE   = 3'b111;

  function automatic logic is_write(input logic [2:0] code);
    return (code == STATUS_IO_WRITE) || (code == STATUS_MEM_WRITE);
  endfunction

  // HALT and PASSIVE are status encodings, not requestable cycles.
  function automatic logic is_legal(input logic [2:0] code);
    return (code != STATUS_HALT) && (code != STATUS_PASSIVE);
  endfunction

endpackage

// File: rtl/cpu_clock_edge_detector.sv
// Detects rising/falling edges of the slower bus phase clock in the system clock
// domain; the strobes are valid for the one clock cycle following each edge.
module cpu_clock_edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic cpu_clock,
  output logic cpu_pos,
  output logic cpu_neg
);

  logic prev_cpu_clock_r;

  // Previous-sample register for cpu_clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_cpu_clock_r <= 1'b0;
    end else begin
      prev_cpu_clock_r <= cpu_clock;
    end
  end

  assign cpu_pos = ~prev_cpu_clock_r & cpu_clock;
  assign cpu_neg = prev_cpu_clock_r & ~cpu_clock;

endmodule

// File: rtl/bus_cycle_initiator.sv
// CPU-side bus interface unit: runs one-word requests through T1/T2/T3/Tw/T4 on
// the cpu_clock grid and drives the status/lock/address/data pattern for the 8288.
module bus_cycle_initiator
  import bus_cycle_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_clock,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_write_data,
  input  logic        req_lock,
  input  logic        ready,
  input  logic [7:0]  data_bus_in,
  output logic [2:0]  processor_status,
  output logic        processor_lock_n,
  output logic [19:0] cpu_address,
  output logic [7:0]  cpu_data_bus,
  output logic        data_out_enable,
  output logic        resp_valid,
  output logic [7:0]  resp_read_data
);

  logic       cpu_pos_s;
  logic       cpu_neg_s;
  logic       edge_unused_s;
  bus_state_e state_r;
  bus_state_e state_next_s;
  logic [2:0] type_r;
  logic [2:0] type_next_s;
  logic [2:0] status_next_s;
  logic       doe_next_s;
  logic       accept_s;
  logic       complete_s;

  cpu_clock_edge_detector u_edge (
    .clock     (clock),
    .reset     (reset),
    .cpu_clock (cpu_clock),
    .cpu_pos   (cpu_pos_s),
    .cpu_neg   (cpu_neg_s)
  );

  // Only rising phase edges matter here; the falling strobe serves the arbiter.
  assign edge_unused_s = cpu_neg_s;

  assign accept_s   = req_valid & cpu_pos_s & ((state_r == IDLE) | (state_r == T4))
                    & is_legal(req_type);
  assign complete_s = cpu_pos_s & ((state_r == T3) | (state_r == TW)) & ready;
  assign req_ready  = accept_s;

  // Next bus state, advancing only on rising cpu_clock edges.
  always_comb begin
    state_next_s = state_r;
    if (cpu_pos_s) begin
      case (state_r)
        IDLE:    state_next_s = accept_s ? T1 : IDLE;
        T1:      state_next_s = T2;
        T2:      state_next_s = T3;
        T3, TW:  state_next_s = ready ? T4 : TW;
        T4:      state_next_s = accept_s ? T1 : IDLE;
        default: state_next_s = IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Registered output values derived from the upcoming state and cycle type.
  always_comb begin
    type_next_s   = accept_s ? req_type : type_r;
    status_next_s = STATUS_PASSIVE;
    doe_next_s    = 1'b0;
    case (state_next_s)
      T1:      status_next_s = type_next_s;
      T2, T3, TW: begin
        status_next_s = type_next_s;
        doe_next_s    = is_write(type_next_s);
      end
      T4:      doe_next_s = is_write(type_next_s);
      default: status_next_s = STATUS_PASSIVE;
    endcase
  end

  // Cycle state and all bus-facing registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      type_r           <= STATUS_PASSIVE;
      processor_status <= STATUS_PASSIVE;
      processor_lock_n <= 1'b1;
      cpu_address      <= 20'h00000;
      cpu_data_bus     <= 8'h00;
      data_out_enable  <= 1'b0;
      resp_valid       <= 1'b0;
      resp_read_data   <= 8'h00;
    end else begin
      state_r          <= state_next_s;
      type_r           <= type_next_s;
      processor_status <= status_next_s;
      data_out_enable  <= doe_next_s;
      resp_valid       <= complete_s;
      if (accept_s) begin
        cpu_address    <= req_address;
        cpu_data_bus   <= req_write_data;
      end
      if (complete_s && !is_write(type_r)) begin
        resp_read_data <= data_bus_in;
      end
      // A locked back-to-back accept out of T4 keeps LOCK asserted.
      if (accept_s) begin
        processor_lock_n <= ~req_lock;
      end else if (cpu_pos_s && (state_r == T4)) begin
        processor_lock_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Directed bench for bus_cycle_initiator: reads, waited writes, back-to-back,
// locked INTA pairs, illegal requests and reset mid-cycle.
module tb_bus_cycle_initiator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_clock = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'b000;
  logic [19:0] req_address = 20'h00000;
  logic [7:0]  req_write_data = 8'h00;
  logic        req_lock = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  data_bus_in = 8'h00;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data_bus;
  logic        data_out_enable;
  logic        resp_valid;
  logic [7:0]  resp_read_data;

  int   tests = 0;
  int   fails = 0;
  logic rdy_seen;

  bus_cycle_initiator dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_clock        (cpu_clock),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_type         (req_type),
    .req_address      (req_address),
    .req_write_data   (req_write_data),
    .req_lock         (req_lock),
    .ready            (ready),
    .data_bus_in      (data_bus_in),
    .processor_status (processor_status),
    .processor_lock_n (processor_lock_n),
    .cpu_address      (cpu_address),
    .cpu_data_bus     (cpu_data_bus),
    .data_out_enable  (data_out_enable),
    .resp_valid       (resp_valid),
    .resp_read_data   (resp_read_data)
  );

  always #5 clock = ~clock;
  always #20 cpu_clock = ~cpu_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cpu_clock period: capture req_ready inside the accept window, then
  // let the FSM advance and settle.
  task automatic cyc();
    @(posedge cpu_clock);
    #1;
    rdy_seen = req_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_status"}, 32'(processor_status), 32'h7);
    chk({tag, "_lock_n"}, 32'(processor_lock_n), 32'h1);
    chk({tag, "_addr"}, 32'(cpu_address), 32'h0);
    chk({tag, "_data"}, 32'(cpu_data_bus), 32'h0);
    chk({tag, "_doe"}, 32'(data_out_enable), 32'h0);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'h0);
    chk({tag, "_rdata"}, 32'(resp_read_data), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
  endtask

  initial begin
    #12;
    check_reset_values("rst");
    @(negedge cpu_clock);
    #1 reset = 1'b0;

    // 1: memory read, no waits
    req_valid = 1'b1; req_type = 3'b101; req_address = 20'h12345; ready = 1'b1;
    data_bus_in = 8'hA5;
    cyc();
    chk("t1_accept", 32'(rdy_seen), 32'h1);
    chk("t1_status_T1", 32'(processor_status), 32'h5);
    chk("t1_addr", 32'(cpu_address), 32'h12345);
    req_valid = 1'b0;
    cyc();
    chk("t1_status_T2", 32'(processor_status), 32'h5);
    chk("t1_doe_T2", 32'(data_out_enable), 32'h0);
    cyc();
    chk("t1_status_T3", 32'(processor_status), 32'h5);
    chk("t1_rvalid_T3", 32'(resp_valid), 32'h0);
    cyc();
    chk("t1_rvalid_T4", 32'(resp_valid), 32'h1);
    chk("t1_rdata", 32'(resp_read_data), 32'hA5);
    chk("t1_status_T4", 32'(processor_status), 32'h7);
    @(posedge clock); #1;
    chk("t1_rvalid_pulse", 32'(resp_valid), 32'h0);
    cyc();
    chk("t1_status_idle", 32'(processor_status), 32'h7);

    // 2: IO write with two wait states
    req_valid = 1'b1; req_type = 3'b010; req_address = 20'h00060;
    req_write_data = 8'h3C; ready = 1'b0;
    cyc();
    chk("t2_accept", 32'(rdy_seen), 32'h1);
    chk("t2_doe_T1", 32'(data_out_enable), 32'h0);
    chk("t2_data", 32'(cpu_data_bus), 32'h3C);
    req_valid = 1'b0;
    cyc();
    chk("t2_doe_T2", 32'(data_out_enable), 32'h1);
    cyc();
    chk("t2_doe_T3", 32'(data_out_enable), 32'h1);
    cyc();
    chk("t2_rvalid_TW1", 32'(resp_valid), 32'h0);
    chk("t2_status_TW1", 32'(processor_status), 32'h2);
    cyc();
    chk("t2_rvalid_TW2", 32'(resp_valid), 32'h0);
    chk("t2_doe_TW2", 32'(data_out_enable), 32'h1);
    ready = 1'b1;
    cyc();
    chk("t2_rvalid_T4", 32'(resp_valid), 32'h1);
    chk("t2_doe_T4", 32'(data_out_enable), 32'h1);
    chk("t2_status_T4", 32'(processor_status), 32'h7);
    chk("t2_rdata_kept", 32'(resp_read_data), 32'hA5);
    cyc();
    chk("t2_doe_idle", 32'(data_out_enable), 32'h0);

    // 3: back-to-back read then code fetch
    req_valid = 1'b1; req_type = 3'b101; req_address = 20'h11111; data_bus_in = 8'h5A;
    cyc();
    chk("t3_accept1", 32'(rdy_seen), 32'h1);
    cyc();
    cyc();
    req_type = 3'b100; req_address = 20'h22222;
    cyc();
    chk("t3_rvalid1", 32'(resp_valid), 32'h1);
    chk("t3_rdata1", 32'(resp_read_data), 32'h5A);
    chk("t3_status_T4", 32'(processor_status), 32'h7);
    data_bus_in = 8'hC3;
    cyc();
    chk("t3_accept2", 32'(rdy_seen), 32'h1);
    chk("t3_status_T1b", 32'(processor_status), 32'h4);
    chk("t3_addr2", 32'(cpu_address), 32'h22222);
    req_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t3_rvalid2", 32'(resp_valid), 32'h1);
    chk("t3_rdata2", 32'(resp_read_data), 32'hC3);
    cyc();

    // 4: locked INTA pair
    req_valid = 1'b1; req_type = 3'b000; req_lock = 1'b1; data_bus_in = 8'h08;
    cyc();
    chk("t4_lock_T1a", 32'(processor_lock_n), 32'h0);
    chk("t4_status_T1a", 32'(processor_status), 32'h0);
    cyc();
    cyc();
    cyc();
    chk("t4_lock_T4a", 32'(processor_lock_n), 32'h0);
    cyc();
    chk("t4_accept2", 32'(rdy_seen), 32'h1);
    chk("t4_lock_T1b", 32'(processor_lock_n), 32'h0);
    req_valid = 1'b0; req_lock = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t4_lock_T4b", 32'(processor_lock_n), 32'h0);
    chk("t4_rdata", 32'(resp_read_data), 32'h08);
    cyc();
    chk("t4_lock_release", 32'(processor_lock_n), 32'h1);

    // 5: illegal request codes
    req_valid = 1'b1; req_type = 3'b111;
    cyc();
    chk("t5_no_accept_111", 32'(rdy_seen), 32'h0);
    chk("t5_status_111", 32'(processor_status), 32'h7);
    req_type = 3'b011;
    cyc();
    chk("t5_no_accept_011", 32'(rdy_seen), 32'h0);
    cyc();
    chk("t5_status_011", 32'(processor_status), 32'h7);
    chk("t5_rvalid", 32'(resp_valid), 32'h0);
    req_valid = 1'b0;

    // 6: reset during a wait state, then a normal memory write
    req_valid = 1'b1; req_type = 3'b101; req_address = 20'h0F0F0; ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t6_status_TW", 32'(processor_status), 32'h5);
    reset = 1'b1;
    #2;
    check_reset_values("t6_rst");
    ready = 1'b1;
    @(negedge cpu_clock);
    #1 reset = 1'b0;
    chk("t6_rvalid_after", 32'(resp_valid), 32'h0);
    req_valid = 1'b1; req_type = 3'b110; req_address = 20'h0ABCD; req_write_data = 8'h77;
    cyc();
    chk("t6_accept", 32'(rdy_seen), 32'h1);
    chk("t6_status_T1", 32'(processor_status), 32'h6);
    req_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t6_rvalid_T4", 32'(resp_valid), 32'h1);
    chk("t6_data", 32'(cpu_data_bus), 32'h77);
    chk("t6_doe_T4", 32'(data_out_enable), 32'h1);
    chk("t6_addr", 32'(cpu_address), 32'h0ABCD);
    cyc();
    chk("t6_status_idle", 32'(processor_status), 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_cycle_initiator.md
# bus_cycle_initiator

- Drives the CPU side of the system bus the way an 8088 bus interface unit does.
- Accepts one-word transaction requests from a local requester and sequences each through T1/T2/T3/Tw/T4 on the `cpu_clock` grid.
- For each cycle it emits the `processor_status` / `processor_lock_n` / `cpu_address` / `cpu_data_bus` pattern that the bus arbiter and its 8288 decoder consume, honours `ready` wait states, and returns read data.
- It sits between the CPU core model (or a test master) and the bus arbiter.

## Interface
Parameters: none.

- clock  input  1  system clock; everything is sampled on its rising edge
- reset  input  1  asynchronous, active-high
- cpu_clock  input  1  bus phase clock, slower than `clock`; edges detected internally
- req_valid  input  1  request pending; held until accepted
- req_ready  output  1  one-`clock` strobe: request accepted this edge
- req_type  input  3  8088 status code: 000 INTA, 001 IO read, 010 IO write, 100 code fetch, 101 mem read, 110 mem write
- req_address  input  20  cycle address
- req_write_data  input  8  write data
- req_lock  input  1  assert LOCK for this cycle
- ready  input  1  synchronised bus ready (low inserts Tw)
- data_bus_in  input  8  bus data returned to CPU
- processor_status  output  3  S2..S0; 3'b111 = passive
- processor_lock_n  output  1  active-low LOCK
- cpu_address  output  20  latched cycle address
- cpu_data_bus  output  8  latched write data
- data_out_enable  output  1  high while write data is valid on `cpu_data_bus`
- resp_valid  output  1  one-`clock` pulse at cycle completion
- resp_read_data  output  8  data captured for read/fetch/INTA cycles

## Operation
Edge detection:
- `prev_cpu_clock` is registered on `clock`.
- cpu_pos = ~prev & cpu_clock; cpu_neg = prev & ~cpu_clock.
- All state transitions occur on `clock` edges where cpu_pos = 1.

States and transitions:
- IDLE -> T1 on accept.
- T1 -> T2 -> T3.
- T3 or TW -> T4 if `ready` = 1, otherwise -> TW.
- T4 -> T1 on accept (back-to-back cycle), otherwise -> IDLE.

Accept:
- Condition: req_valid & cpu_pos & state ∈ {IDLE, T4} & legal req_type.
- On accept: req_ready = 1 for that clock; latch type, address, write data and lock.
- Illegal types 011 and 111: never accepted; req_ready stays 0; no bus activity.

processor_status:
- Equals the latched type in T1, T2, T3 and TW.
- 3'b111 in IDLE and T4.

cpu_address:
- Updated only on accept; otherwise holds its value.

Write types (010, 110):
- `cpu_data_bus` = latched data; updated on accept.
- data_out_enable = 1 in T2, T3, TW and T4.

Read-type cycles (000, 001, 100, 101):
- On the T3/TW -> T4 transition, `resp_read_data` <= `data_bus_in`.

resp_valid:
- Pulses for 1 clock on the T3/TW -> T4 transition, for all types.
- `resp_read_data` holds its value until the next read completion.

processor_lock_n:
- Goes 0 on accept when req_lock = 1.
- Returns to 1 on leaving T4, unless a locked back-to-back accept occurs at that edge, in which case it stays 0.

Reset:
- Asynchronous.
- State IDLE; status 3'b111; lock_n 1; address 0; data 0; data_out_enable 0; req_ready 0; resp_valid 0; resp_read_data 0; prev_cpu_clock 0.
- Reset mid-cycle aborts the cycle with no resp_valid.

## Timing
- Minimum cycle length is 4 `cpu_clock` periods (T1–T4); each Tw adds 1.
- `ready` is sampled only at cpu_pos while in T3 or TW.
- Latency from accept to resp_valid is 3 + Nwait cpu_clock periods.
- Back-to-back cycles: the next T1 follows T4 directly, with no IDLE.
- Status is passive for exactly one cpu_clock period (T4) between cycles; the arbiter's hold logic relies on seeing x11 there.
- req_valid asserted mid-cycle waits for T4 or IDLE.
- If req_valid drops before accept, nothing happens.
- Outputs are registered, except req_ready, which is a combinational strobe gated by cpu_pos.

## Structure
- Shared package `bus_cycle_pkg` holds:
  - the bus-cycle state enum (IDLE, T1, T2, T3, TW, T4);
  - status code constants (STATUS_INTA, STATUS_IO_READ, STATUS_IO_WRITE, STATUS_HALT, STATUS_CODE, STATUS_MEM_READ, STATUS_MEM_WRITE, STATUS_PASSIVE);
  - an is_write / is_legal helper.
- One sub-module, `cpu_clock_edge_detector` (outputs cpu_pos / cpu_neg), is natural and reusable by the arbiter.

## Test plan
1. Reset, then req 101 at 0x12345 with ready=1 -> status 101 for 3 cpu periods; resp_valid after 3 periods; resp_read_data = data_bus_in (0xA5); status 111 in T4.
2. IO write 010, address 0x00060, data 0x3C, ready low for 2 samples -> two TW states; data_out_enable high T2–T4; cpu_data_bus = 0x3C; resp_valid at T4 entry.
3. req_valid held with two requests back-to-back -> second T1 immediately after T4; status 111 for exactly one cpu period between cycles.
4. Locked INTA (000, req_lock=1) followed by a locked INTA -> processor_lock_n stays 0 from first accept to end of second T4, then returns to 1.
5. req_type 111 or 011 -> no req_ready, status stays 111.
6. Assert reset during TW -> all outputs return to reset values immediately; no resp_valid; a new request afterwards runs normally.
